// File: rtl/digit_uart_tx.sv
// digit_uart_tx: buffers BCD digits and streams them as ASCII
// over an 8N1 UART, closing each digit stream with CR LF.
module digit_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       digits_done,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic [CW-1:0] pre_cnt;
  state_t        state;
  logic          eol_pending;
  logic          eol_step;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic [BW-1:0] baud;
  logic          full;
  logic          empty;
  logic          eol_go;
  logic          pop;
  logic          push;
  logic          baud_end;

  function automatic logic [7:0] to_ascii(
    input logic [3:0] d
  );
    return (d <= 4'd9) ? {4'h3, d} : 8'h3F;
  endfunction

  // pre_cnt holds the digits queued ahead of a pending CR LF,
  // so later digits wait until after the LF
  always_comb begin
    full     = (count == CW'(FIFO_DEPTH));
    empty    = (count == '0);
    eol_go   = (state == IDLE) && eol_pending
             && (eol_step || pre_cnt == '0);
    pop      = (state == IDLE) && !eol_go && !empty;
    push     = digit_valid && (!full || pop);
    count_nx = count;
    if (push && !pop)
      count_nx = count + CW'(1);
    else if (!push && pop)
      count_nx = count - CW'(1);
    baud_end = (baud == BW'(CLKS_PER_BIT - 1));
  end

  // Digit storage array
  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr] <= digit_in;
  end

  // FIFO pointers, occupancy, overflow and end-of-line tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      eol_pending <= 1'b0;
      eol_step    <= 1'b0;
      pre_cnt     <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_nx;
      if (digit_valid && !push)
        overflow <= 1'b1;
      if (eol_go && eol_step) begin
        eol_pending <= 1'b0;
        eol_step    <= 1'b0;
      end else if (eol_go) begin
        eol_step <= 1'b1;
      end else if (digits_done && !eol_pending) begin
        eol_pending <= 1'b1;
        pre_cnt     <= count_nx;
      end else if (pop && pre_cnt != '0) begin
        pre_cnt <= pre_cnt - CW'(1);
      end
    end
  end

  // UART framing FSM with registered serial output
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
      baud    <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud    <= '0;
          bit_idx <= '0;
          if (pop || eol_go) begin
            tx    <= 1'b0;
            state <= START;
            if (pop)
              shreg <= to_ascii(mem[rd_ptr]);
            else
              shreg <= eol_step ? 8'h0A : 8'h0D;
          end else begin
            tx <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud  <= '0;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx    <= shreg[0];
              shreg <= shreg >> 1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Activity flag, registered from current buffer/FSM state
  always_ff @(posedge clk) begin
    if (rst)
      busy <= 1'b0;
    else
      busy <= !empty || (state != IDLE) || eol_pending;
  end

endmodule

// File: tb/tb_digit_uart_tx.sv
// tb_digit_uart_tx: directed stimulus with a byte scoreboard
// checked against frames decoded from the tx line.
module tb_digit_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 256;
  localparam int FRAME = 10 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_in = 4'd0;
  logic       digit_valid = 1'b0;
  logic       digits_done = 1'b0;
  logic       tx;
  logic       busy;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic mon_en = 1'b1;
  logic busy_chk = 1'b0;
  logic gap_chk = 1'b0;
  logic have_prev = 1'b0;
  logic start_chk = 1'b0;
  int   exp_start = 0;
  int   prev_stop = 0;

  digit_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit_in   (digit_in),
    .digit_valid(digit_valid),
    .digits_done(digits_done),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] asc(input int d);
    return (d < 10) ? 8'(48 + d) : 8'h3F;
  endfunction

  task automatic step(
    input logic       v,
    input logic [3:0] d,
    input logic       dn
  );
    digit_valid = v;
    digit_in    = d;
    digits_done = dn;
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    digits_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
    idle(3);
  endtask

  // frame decoder and scoreboard consumer
  initial begin : mon
    logic [7:0] b;
    logic       s0;
    int         bad;
    int         st;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx === 1'b0) begin
        st  = cyc;
        bad = 0;
        b   = '0;
        if (start_chk) begin
          check("start_latency", st, exp_start);
          start_chk = 1'b0;
        end
        if (gap_chk && have_prev)
          check("idle_gap", st - prev_stop, 2);
        repeat (CPB - 1) begin
          @(negedge clk);
          if (tx !== 1'b0) bad++;
        end
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          s0   = tx;
          b[i] = s0;
          repeat (CPB - 1) begin
            @(negedge clk);
            if (tx !== s0) bad++;
          end
        end
        repeat (CPB) begin
          @(negedge clk);
          if (tx !== 1'b1) bad++;
        end
        prev_stop = cyc;
        have_prev = 1'b1;
        check("frame_shape", bad, 0);
        check("frame_expected",
              32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          check("frame_byte", b, exp_q.pop_front());
        if (busy_chk && exp_q.size() == 0) begin
          @(negedge clk);
          check("busy_after_lf", busy, 1'b1);
          @(negedge clk);
          check("busy_fall", busy, 1'b0);
          busy_chk = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   occ;
    int   next_pop;
    int   lows;
    logic pm;
    logic acc;

    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_ovf", overflow, 1'b0);

    // single digit then end of line
    gap_chk   = 1'b1;
    have_prev = 1'b0;
    busy_chk  = 1'b1;
    exp_start = cyc + 2;
    start_chk = 1'b1;
    exp_q.push_back(asc(7));
    step(1'b1, 4'd7, 1'b0);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    step(1'b0, 4'd0, 1'b1);
    drain("t1_drain", 400);
    check("t1_busy_chk_ran", busy_chk, 1'b0);
    check("t1_start_chk_ran", start_chk, 1'b0);

    // 150 digit stream, back-to-back frames
    have_prev = 1'b0;
    for (int i = 0; i < 150; i++) begin
      exp_q.push_back(asc(i % 10));
      step(1'b1, 4'(i % 10), 1'b0);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    step(1'b0, 4'd0, 1'b1);
    drain("t2_drain", 160 * FRAME);
    check("t2_overflow", overflow, 1'b0);
    gap_chk = 1'b0;

    // non-decimal digit; done with the last digit
    exp_q.push_back(8'h3F);
    step(1'b1, 4'hB, 1'b0);
    exp_q.push_back(asc(4));
    step(1'b1, 4'd4, 1'b0);
    exp_q.push_back(asc(5));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    step(1'b1, 4'd5, 1'b1);
    drain("t3_drain", 10 * FRAME);

    // repeated done is ignored; late digit follows LF
    exp_q.push_back(asc(3));
    step(1'b1, 4'd3, 1'b0);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    step(1'b0, 4'd0, 1'b1);
    idle(3);
    step(1'b0, 4'd0, 1'b1);
    exp_q.push_back(asc(8));
    step(1'b1, 4'd8, 1'b0);
    step(1'b0, 4'd0, 1'b1);
    drain("t4_drain", 10 * FRAME);
    check("t4_overflow", overflow, 1'b0);

    // 300 digit burst into a 256 entry buffer
    occ      = 0;
    next_pop = 1;
    for (int i = 0; i < 300; i++) begin
      pm  = (i == next_pop);
      acc = (occ < DEPTH) || pm;
      if (acc) exp_q.push_back(asc(i % 10));
      occ = occ + int'(acc) - int'(pm);
      if (pm) next_pop += FRAME;
      step(1'b1, 4'(i % 10), 1'b0);
    end
    check("t5_overflow", overflow, 1'b1);
    drain("t5_drain", 300 * FRAME);
    check("t5_ovf_sticky", overflow, 1'b1);

    // reset in the middle of the second frame's data bits
    mon_en = 1'b0;
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 1'b0);
    idle(58);
    check("t6_busy_mid", busy, 1'b1);
    rst         = 1'b1;
    digit_valid = 1'b1;
    digit_in    = 4'd9;
    digits_done = 1'b1;
    idle(1);
    check("t6_tx_reset", tx, 1'b1);
    check("t6_busy_reset", busy, 1'b0);
    check("t6_ovf_reset", overflow, 1'b0);
    rst         = 1'b0;
    digit_valid = 1'b0;
    digits_done = 1'b0;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("t6_quiet_after", lows, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
